id_ex_latch: RTL
================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 SHALL have parameter HALT_STICKY, default 1: 1 = halt_ex held until reset once latched; 0 = halt_ex follows the pipeline.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- CLK  in  1  rising-edge clock
- RST  in  1  async reset, active-high
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_busy  in  1  MEM stage holds an outstanding dmem read/write
- flush  in  1  branch/jump redirect; squash ID instruction
- valid_id, regWrite_id, memRead_id, memWrite_id, halt_id  in  1 each  ID-stage controls
- aluop_id  in  aluop_t  ALU operation
- rs_id, rt_id, regSel_id  in  regbits_t (5)  source regs / destination
- rdat1_id, rdat2_id, imm_id, pc4_id  in  word_t (32)  operands, extended immediate, PC+4
- *_ex  out  same widths  registered copies of every *_id field above
- stall_id  out  1  load-use hazard; hold PC and IF/ID

Function
REQ-003 SHALL compute advance = (ihit & ~mem_busy) | dhit; the latch updates only when advance=1 and otherwise holds all *_ex values.
REQ-004 SHALL raise stall_id combinationally when memRead_ex=1, valid_ex=1, regSel_ex!=0, and regSel_ex equals rs_id or rt_id.
REQ-005 On advance with flush=1 or stall_id=1, SHALL load a bubble: valid, regWrite, memRead, memWrite, halt, regSel, rs, rt = 0; aluop = ALU_SLL; data fields = 0.
REQ-006 Otherwise on advance, SHALL copy every *_id field to its *_ex output with one-cycle latency.
REQ-007 If flush and stall_id are both 1, flush SHALL take priority; the result is a bubble and stall_id is still driven.
REQ-008 SHALL hold stall_id high for exactly one advancing cycle per load-use pair; after the bubble, memRead_ex=0 drops stall_id.
REQ-009 When advance=0, SHALL keep stall_id as computed from held state; no bubble is inserted and no field changes.
REQ-010 With HALT_STICKY=1, once halt_ex=1, SHALL ignore flush and bubbles for halt_ex and keep it at 1 until RST.
REQ-011 rs_ex and rt_ex SHALL be valid for the forwarding unit in the same cycle as the corresponding rdat*_ex.
REQ-012 A register index of 0 SHALL never cause a stall.

Reset
REQ-013 RST SHALL asynchronously force every *_ex output to the bubble values of REQ-005 and clear the sticky halt.
REQ-014 The first advance after RST deasserts SHALL load normally; RST asserted mid-stall SHALL clear stall_id within the same cycle, because it depends on memRead_ex=0.

Structure
REQ-015 aluop_t, regbits_t, word_t and the ALU_SLL encoding SHALL come from cpu_types_pkg; no new package types are introduced.
REQ-016 The ID/EX fields SHALL be bundled in an interface id_ex_if with modports id, ex and tb.
REQ-017 Load-use detection SHALL be a sub-module, load_use_detect, that is purely combinational.

Verification
REQ-018 Reset: RST=1 mid-run -> all *_ex=0, aluop_ex=ALU_SLL, stall_id=0, halt_ex=0 without waiting for CLK.
REQ-019 Normal advance: ihit=1, regSel_id=5, rdat1_id=0x1234 -> next edge regSel_ex=5, rdat1_ex=0x1234.
REQ-020 Load-use: lw to $8 in EX, rs_id=8, ihit=1 -> stall_id=1; next edge bubble (valid_ex=0); following cycle stall_id=0.
REQ-021 Memory stall: mem_busy=1, ihit=1, dhit=0 for 3 cycles -> *_ex unchanged; dhit=1 -> update on that edge.
REQ-022 Flush plus load-use in the same cycle -> bubble; next instruction then loads normally.
REQ-023 Halt: halt_id=1 latched, then flush=1 -> halt_ex remains 1 until RST.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: ALU opcodes, register index and word.
// Imported by the pipeline latches and the hazard logic.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_if.sv
// One ID/EX control+data bundle.
// Modports: id (producer), ex (consumer), tb (observer).
interface id_ex_if;
    import cpu_types_pkg::*;

    logic     valid;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     halt;
    aluop_t   aluop;
    regbits_t rs;
    regbits_t rt;
    regbits_t reg_sel;
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    word_t    pc4;

    modport id (
        output valid, reg_write, mem_read, mem_write, halt,
        output aluop, rs, rt, reg_sel,
        output rdat1, rdat2, imm, pc4
    );

    modport ex (
        input valid, reg_write, mem_read, mem_write, halt,
        input aluop, rs, rt, reg_sel,
        input rdat1, rdat2, imm, pc4
    );

    modport tb (
        input valid, reg_write, mem_read, mem_write, halt,
        input aluop, rs, rt, reg_sel,
        input rdat1, rdat2, imm, pc4
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check against the instruction in EX.
// Ports: ex (EX bundle), rs_id/rt_id (ID sources), stall (hazard).
module load_use_detect
    import cpu_types_pkg::*;
(
    id_ex_if.ex      ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    output logic     stall
);

    logic dst_live;
    logic src_hit;

    // $0 is hardwired, so a load targeting it never produces a value
    assign dst_live = ex.valid & ex.mem_read & (ex.reg_sel != REG_ZERO);
    assign src_hit  = (ex.reg_sel == rs_id) | (ex.reg_sel == rt_id);
    assign stall    = dst_live & src_hit;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion and sticky halt.
// Ports: CLK/RST, ihit/dhit/mem_busy/flush, *_id in, *_ex out, stall_id.
module id_ex_latch
    import cpu_types_pkg::*;
#(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     mem_busy,
    input  logic     flush,
    input  logic     valid_id,
    input  logic     regWrite_id,
    input  logic     memRead_id,
    input  logic     memWrite_id,
    input  logic     halt_id,
    input  aluop_t   aluop_id,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    input  regbits_t regSel_id,
    input  word_t    rdat1_id,
    input  word_t    rdat2_id,
    input  word_t    imm_id,
    input  word_t    pc4_id,
    output logic     valid_ex,
    output logic     regWrite_ex,
    output logic     memRead_ex,
    output logic     memWrite_ex,
    output logic     halt_ex,
    output aluop_t   aluop_ex,
    output regbits_t rs_ex,
    output regbits_t rt_ex,
    output regbits_t regSel_ex,
    output word_t    rdat1_ex,
    output word_t    rdat2_ex,
    output word_t    imm_ex,
    output word_t    pc4_ex,
    output logic     stall_id
);

    id_ex_if u_id ();
    id_ex_if u_ex ();

    logic     advance;
    logic     bubble;

    logic     valid_d,     valid_q;
    logic     reg_write_d, reg_write_q;
    logic     mem_read_d,  mem_read_q;
    logic     mem_write_d, mem_write_q;
    logic     halt_d,      halt_q;
    aluop_t   aluop_d,     aluop_q;
    regbits_t rs_d,        rs_q;
    regbits_t rt_d,        rt_q;
    regbits_t reg_sel_d,   reg_sel_q;
    word_t    rdat1_d,     rdat1_q;
    word_t    rdat2_d,     rdat2_q;
    word_t    imm_d,       imm_q;
    word_t    pc4_d,       pc4_q;

    assign u_id.valid     = valid_id;
    assign u_id.reg_write = regWrite_id;
    assign u_id.mem_read  = memRead_id;
    assign u_id.mem_write = memWrite_id;
    assign u_id.halt      = halt_id;
    assign u_id.aluop     = aluop_id;
    assign u_id.rs        = rs_id;
    assign u_id.rt        = rt_id;
    assign u_id.reg_sel   = regSel_id;
    assign u_id.rdat1     = rdat1_id;
    assign u_id.rdat2     = rdat2_id;
    assign u_id.imm       = imm_id;
    assign u_id.pc4       = pc4_id;

    assign u_ex.valid     = valid_q;
    assign u_ex.reg_write = reg_write_q;
    assign u_ex.mem_read  = mem_read_q;
    assign u_ex.mem_write = mem_write_q;
    assign u_ex.halt      = halt_q;
    assign u_ex.aluop     = aluop_q;
    assign u_ex.rs        = rs_q;
    assign u_ex.rt        = rt_q;
    assign u_ex.reg_sel   = reg_sel_q;
    assign u_ex.rdat1     = rdat1_q;
    assign u_ex.rdat2     = rdat2_q;
    assign u_ex.imm       = imm_q;
    assign u_ex.pc4       = pc4_q;

    load_use_detect u_lud (
        .ex    (u_ex),
        .rs_id (rs_id),
        .rt_id (rt_id),
        .stall (stall_id)
    );

    // A completing data access lets the pipe move even while fetch waits
    assign advance = (ihit & ~mem_busy) | dhit;
    assign bubble  = flush | stall_id;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        halt_d      = halt_q;
        aluop_d     = aluop_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        reg_sel_d   = reg_sel_q;
        rdat1_d     = rdat1_q;
        rdat2_d     = rdat2_q;
        imm_d       = imm_q;
        pc4_d       = pc4_q;
        if (advance) begin
            if (bubble) begin
                valid_d     = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                halt_d      = 1'b0;
                aluop_d     = ALU_SLL;
                rs_d        = '0;
                rt_d        = '0;
                reg_sel_d   = '0;
                rdat1_d     = '0;
                rdat2_d     = '0;
                imm_d       = '0;
                pc4_d       = '0;
            end else begin
                valid_d     = u_id.valid;
                reg_write_d = u_id.reg_write;
                mem_read_d  = u_id.mem_read;
                mem_write_d = u_id.mem_write;
                halt_d      = u_id.halt;
                aluop_d     = u_id.aluop;
                rs_d        = u_id.rs;
                rt_d        = u_id.rt;
                reg_sel_d   = u_id.reg_sel;
                rdat1_d     = u_id.rdat1;
                rdat2_d     = u_id.rdat2;
                imm_d       = u_id.imm;
                pc4_d       = u_id.pc4;
            end
        end
        // A latched halt survives later flushes and bubbles
        if (HALT_STICKY && halt_q) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halt_q      <= 1'b0;
            aluop_q     <= ALU_SLL;
            rs_q        <= '0;
            rt_q        <= '0;
            reg_sel_q   <= '0;
            rdat1_q     <= '0;
            rdat2_q     <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            halt_q      <= halt_d;
            aluop_q     <= aluop_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            reg_sel_q   <= reg_sel_d;
            rdat1_q     <= rdat1_d;
            rdat2_q     <= rdat2_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
        end
    end

    assign valid_ex    = u_ex.valid;
    assign regWrite_ex = u_ex.reg_write;
    assign memRead_ex  = u_ex.mem_read;
    assign memWrite_ex = u_ex.mem_write;
    assign halt_ex     = u_ex.halt;
    assign aluop_ex    = u_ex.aluop;
    assign rs_ex       = u_ex.rs;
    assign rt_ex       = u_ex.rt;
    assign regSel_ex   = u_ex.reg_sel;
    assign rdat1_ex    = u_ex.rdat1;
    assign rdat2_ex    = u_ex.rdat2;
    assign imm_ex      = u_ex.imm;
    assign pc4_ex      = u_ex.pc4;

endmodule
